// File: rtl/fft_pkg.sv
// fft_pkg: sizes, FSM encoding and elaboration-time helpers for the
// 512-point iterative radix-2 DIT FFT (fft_top, fft_butterfly).
package fft_pkg;

    localparam int N_LOG2 = 9;
    localparam int N      = 1 << N_LOG2;
    localparam int DATA_W = 24;
    localparam int TWID_W = 16;
    localparam int MAG_W  = 24;
    localparam int IW     = DATA_W + 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_OUTPUT  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef struct packed {
        logic signed [IW-1:0] re;
        logic signed [IW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TWID_W-1:0] re;
        logic signed [TWID_W-1:0] im;
    } twid_t;

    localparam longint Q30_ONE = 64'sd1073741824;
    localparam longint PI_Q30  = 64'sd3373259426;

    function automatic logic [N_LOG2-1:0] bit_rev(input logic [N_LOG2-1:0] a);
        logic [N_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
        return r;
    endfunction

    // Q30 Taylor series for sin/cos on [0, pi/2), integer-only so the
    // ROM can be built as constants.
    function automatic longint q30_taylor(input longint x, input bit is_sin);
        longint x2;
        longint term;
        longint sum;
        x2   = (x * x) >>> 30;
        term = is_sin ? x : Q30_ONE;
        sum  = term;
        for (int i = 1; i <= 12; i++) begin
            if (is_sin) term = -((term * x2) >>> 30) / longint'((2*i) * (2*i + 1));
            else        term = -((term * x2) >>> 30) / longint'((2*i - 1) * (2*i));
            sum = sum + term;
        end
        return sum;
    endfunction

    function automatic logic signed [TWID_W-1:0] q15_sat(input longint v);
        longint r;
        r = (v + 64'sd16384) >>> 15;
        if (r > 64'sd32767)  r = 64'sd32767;
        if (r < -64'sd32768) r = -64'sd32768;
        return TWID_W'(r);
    endfunction

    // W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), k in 0..N/2-1.
    function automatic twid_t tw_init(input int k);
        longint phi;
        longint c;
        longint s;
        twid_t  w;
        phi = (longint'(k % (N / 4)) * PI_Q30) / longint'(N / 2);
        c   = q30_taylor(phi, 1'b0);
        s   = q30_taylor(phi, 1'b1);
        if (k >= N / 4) begin
            w.re = q15_sat(-s);
            w.im = q15_sat(-c);
        end else begin
            w.re = q15_sat(c);
            w.im = q15_sat(-s);
        end
        return w;
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// fft_butterfly: combinational radix-2 DIT butterfly with 1/2 scaling.
// t = b*w (>>>15), ya = (a+t)>>>1, yb = (a-t)>>>1, all truncating.
module fft_butterfly
    import fft_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    input  twid_t w,
    output cplx_t ya,
    output cplx_t yb
);

    localparam int PW = IW + TWID_W + 1;
    localparam int TW = IW + 2;
    localparam int SW = IW + 3;

    logic signed [PW-1:0] p_re;
    logic signed [PW-1:0] p_im;
    logic signed [TW-1:0] t_re;
    logic signed [TW-1:0] t_im;

    // Complex multiply, Q1.15 truncation, then halved add/sub.
    always_comb begin
        p_re = PW'($signed(b.re)) * PW'($signed(w.re))
             - PW'($signed(b.im)) * PW'($signed(w.im));
        p_im = PW'($signed(b.re)) * PW'($signed(w.im))
             + PW'($signed(b.im)) * PW'($signed(w.re));
        t_re = TW'(p_re >>> 15);
        t_im = TW'(p_im >>> 15);
        ya.re = IW'((SW'($signed(a.re)) + SW'(t_re)) >>> 1);
        ya.im = IW'((SW'($signed(a.im)) + SW'(t_im)) >>> 1);
        yb.re = IW'((SW'($signed(a.re)) - SW'(t_re)) >>> 1);
        yb.im = IW'((SW'($signed(a.im)) - SW'(t_im)) >>> 1);
    end

endmodule

// File: rtl/fft_top.sv
// fft_top: iterative in-place 512-point FFT, one butterfly, 3 cycles each.
// Define FFT_HALF_SPECTRUM_EN to emit only bins 0..N/2-1.
module fft_top
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_buffer_data_ready,
    input  logic [DATA_W-1:0] i_buffer_data,
    output logic [N_LOG2-1:0] o_buffer_read_addr,
    output logic [N_LOG2-1:0] o_fft_magnitude_addr,
    output logic [MAG_W-1:0]  o_fft_magnitude_out,
    output logic              o_fft_out_valid,
    output logic              o_fft_done_pulse,
    output logic              o_fft_busy
);

`ifdef FFT_HALF_SPECTRUM_EN
    localparam int N_OUT = N / 2;
`else
    localparam int N_OUT = N;
`endif
    localparam int SUM_W = IW + 1;
    localparam int BF_W  = N_LOG2 - 1;

    localparam logic [N_LOG2-1:0] ONE        = 1;
    localparam logic [BF_W-1:0]   BF_ONE     = 1;
    localparam logic [BF_W-1:0]   LAST_BF    = '1;
    localparam logic [3:0]        LAST_STAGE = 4'(N_LOG2 - 1);
    localparam logic [N_LOG2-1:0] LAST_BIN   = N_LOG2'(N_OUT - 1);
    localparam logic [SUM_W-1:0]  MAG_MAX    = SUM_W'((1 << MAG_W) - 1);

    logic [2:0]        state;
    logic [N_LOG2-1:0] ld_cnt;
    logic [N_LOG2-1:0] out_cnt;
    logic [3:0]        stage;
    logic [BF_W-1:0]   bf;
    logic [1:0]        phase;

    cplx_t mem [N];
    twid_t tw_rom [N/2];

    cplx_t a_q, b_q, ya, yb, ya_q, yb_q, rd_q;
    twid_t w_q;
    logic [N_LOG2-1:0] rd_bin;
    logic              rd_vld;

    logic [N_LOG2-1:0] half, pos, idx_a, idx_b;
    logic [BF_W-1:0]   tw_idx;

    logic [IW-1:0]    abs_re, abs_im, mx, mn;
    logic [SUM_W-1:0] mag_sum;

    for (genvar g = 0; g < N/2; g++) begin : g_tw
        localparam twid_t TW_K = tw_init(g);
        assign tw_rom[g] = TW_K;
    end

    fft_butterfly u_bfly (
        .a  (a_q),
        .b  (b_q),
        .w  (w_q),
        .ya (ya),
        .yb (yb)
    );

    assign o_buffer_read_addr   = ld_cnt;
    assign o_fft_magnitude_addr = rd_bin;
    assign o_fft_out_valid      = rd_vld;

    // Butterfly pair and twiddle index for (stage, butterfly).
    always_comb begin
        half   = ONE << stage;
        pos    = {1'b0, bf} & (half - ONE);
        idx_a  = (({1'b0, bf} - pos) << 1) | pos;
        idx_b  = idx_a | half;
        tw_idx = BF_W'(pos << (LAST_STAGE - stage));
    end

    // Magnitude approx max + min/4 + min/8 of the registered bin.
    always_comb begin
        abs_re = rd_q.re[IW-1] ? IW'(-rd_q.re) : IW'(rd_q.re);
        abs_im = rd_q.im[IW-1] ? IW'(-rd_q.im) : IW'(rd_q.im);
        mx = abs_re;
        mn = abs_im;
        if (abs_im > abs_re) begin
            mx = abs_im;
            mn = abs_re;
        end
        mag_sum = {1'b0, mx} + SUM_W'(mn >> 2) + SUM_W'(mn >> 3);
        o_fft_magnitude_out = (mag_sum > MAG_MAX) ? '1 : MAG_W'(mag_sum);
    end

    // Frame FSM, address counters and butterfly/output pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            ld_cnt           <= '0;
            out_cnt          <= '0;
            stage            <= '0;
            bf               <= '0;
            phase            <= '0;
            a_q              <= '0;
            b_q              <= '0;
            w_q              <= '0;
            ya_q             <= '0;
            yb_q             <= '0;
            rd_q             <= '0;
            rd_bin           <= '0;
            rd_vld           <= 1'b0;
            o_fft_done_pulse <= 1'b0;
            o_fft_busy       <= 1'b0;
        end else begin
            rd_vld           <= 1'b0;
            o_fft_done_pulse <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_buffer_data_ready) begin
                        state      <= ST_LOAD;
                        o_fft_busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    ld_cnt <= ld_cnt + ONE;
                    if (ld_cnt == '1) state <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    phase <= phase + 2'd1;
                    unique case (phase)
                        2'd0: begin
                            a_q <= mem[idx_a];
                            b_q <= mem[idx_b];
                            w_q <= tw_rom[tw_idx];
                        end
                        2'd1: begin
                            ya_q <= ya;
                            yb_q <= yb;
                        end
                        default: begin
                            phase <= 2'd0;
                            bf    <= bf + BF_ONE;
                            if (bf == LAST_BF) begin
                                stage <= stage + 4'd1;
                                if (stage == LAST_STAGE) begin
                                    stage <= '0;
                                    state <= ST_OUTPUT;
                                end
                            end
                        end
                    endcase
                end
                ST_OUTPUT: begin
                    rd_q    <= mem[out_cnt];
                    rd_bin  <= out_cnt;
                    rd_vld  <= 1'b1;
                    out_cnt <= out_cnt + ONE;
                    if (out_cnt == LAST_BIN) begin
                        out_cnt <= '0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_fft_done_pulse <= 1'b1;
                    o_fft_busy       <= 1'b0;
                    state            <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data RAM: bit-reversed real load, then in-place butterfly writeback.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) begin
            mem[bit_rev(ld_cnt)] <= {{(IW-DATA_W){i_buffer_data[DATA_W-1]}},
                                     i_buffer_data, {IW{1'b0}}};
        end
        if (state == ST_COMPUTE && phase == 2'd2) begin
            mem[idx_a] <= ya_q;
            mem[idx_b] <= yb_q;
        end
    end

endmodule

// File: tb/tb_fft_top.sv
// tb_fft_top: directed bench for fft_top with square, DC and impulse
// frames, a mid-compute abort and output protocol checks.
`timescale 1ns/1ps
module tb_fft_top;

    localparam int N = 512;
`ifdef FFT_HALF_SPECTRUM_EN
    localparam int NB = 256;
`else
    localparam int NB = 512;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [23:0] i_buffer_data;
    logic [8:0]  o_buffer_read_addr;
    logic [8:0]  o_fft_magnitude_addr;
    logic [23:0] o_fft_magnitude_out;
    logic        o_fft_out_valid;
    logic        o_fft_done_pulse;
    logic        o_fft_busy;

    int pattern;
    int n_assert = 0;
    int n_fail = 0;
    int mags [N];

    always #5 clk = ~clk;

    function automatic logic [23:0] sample(input int pat, input logic [8:0] a);
        logic [23:0] v;
        v = '0;
        case (pat)
            1: v = (a < 9'd256) ? 24'd10000 : 24'(-10000);
            2: v = 24'd10000;
            3: v = (a == 9'd0) ? 24'd1048576 : 24'd0;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign i_buffer_data = sample(pattern, o_buffer_read_addr);

    fft_top dut (
        .clk                  (clk),
        .reset                (reset),
        .i_buffer_data_ready  (ready),
        .i_buffer_data        (i_buffer_data),
        .o_buffer_read_addr   (o_buffer_read_addr),
        .o_fft_magnitude_addr (o_fft_magnitude_addr),
        .o_fft_magnitude_out  (o_fft_magnitude_out),
        .o_fft_out_valid      (o_fft_out_valid),
        .o_fft_done_pulse     (o_fft_done_pulse),
        .o_fft_busy           (o_fft_busy)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk_eq({tag, "_busy"}, 32'(o_fft_busy), 0);
        chk_eq({tag, "_valid"}, 32'(o_fft_out_valid), 0);
        chk_eq({tag, "_done"}, 32'(o_fft_done_pulse), 0);
        chk_eq({tag, "_rd_addr"}, 32'(o_buffer_read_addr), 0);
        chk_eq({tag, "_mag_addr"}, 32'(o_fft_magnitude_addr), 0);
    endtask

    task automatic run_frame(input int pat, input string name);
        int cyc, addr_err, beats, gaps, busy_err, lat, nxt;
        bit done_seen;
        logic busy_at_done, valid_at_done;
        for (int k = 0; k < N; k++) mags[k] = -1;
        pattern = pat;
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        cyc = 1;
        chk_eq({name, "_busy_start"}, 32'(o_fft_busy), 1);
        addr_err = 0;
        for (int a = 0; a < N; a++) begin
            if (o_buffer_read_addr !== 9'(a)) addr_err++;
            @(negedge clk);
            cyc++;
        end
        chk_eq({name, "_load_addr_seq"}, addr_err, 0);
        beats = 0; gaps = 0; busy_err = 0; lat = 0; nxt = 0;
        done_seen = 1'b0; busy_at_done = 1'bx; valid_at_done = 1'bx;
        while (!done_seen && cyc < 20000) begin
            if (o_fft_out_valid === 1'b1) begin
                if (o_fft_magnitude_addr !== 9'(nxt)) gaps++;
                mags[o_fft_magnitude_addr] = int'(o_fft_magnitude_out);
                nxt++;
                beats++;
            end
            if (o_fft_done_pulse === 1'b1) begin
                done_seen = 1'b1;
                lat = cyc;
                busy_at_done = o_fft_busy;
                valid_at_done = o_fft_out_valid;
            end else begin
                if (o_fft_busy !== 1'b1) busy_err++;
                @(negedge clk);
                cyc++;
            end
        end
        chk_eq({name, "_done_seen"}, 32'(done_seen), 1);
        chk_eq({name, "_beats"}, beats, NB);
        chk_eq({name, "_addr_gaps"}, gaps, 0);
        chk_eq({name, "_busy_held"}, busy_err, 0);
        chk_eq({name, "_busy_at_done"}, 32'(busy_at_done), 0);
        chk_eq({name, "_valid_at_done"}, 32'(valid_at_done), 0);
        chk_rng({name, "_done_latency"}, lat, 7000, 8500);
        @(negedge clk);
        chk_eq({name, "_done_single"}, 32'(o_fft_done_pulse), 0);
        chk_eq({name, "_busy_after"}, 32'(o_fft_busy), 0);
        chk_eq({name, "_hold_addr"}, 32'(o_fft_magnitude_addr), NB - 1);
        chk_eq({name, "_hold_mag"}, 32'(o_fft_magnitude_out), 32'(mags[NB-1]));
    endtask

    initial begin
        int emax, emin, abort_err;
        reset = 1'b1;
        ready = 1'b0;
        pattern = 0;

        repeat (5) @(negedge clk);
        chk_idle("reset_held");
        chk_eq("reset_mag", 32'(o_fft_magnitude_out), 0);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");

        run_frame(1, "square");
        chk_rng("sq_bin0", mags[0], 0, 4);
        emax = 0;
        for (int k = 0; k < NB; k += 2) if (mags[k] > emax || mags[k] < 0) emax = (mags[k] < 0) ? 99999 : mags[k];
        chk_rng("sq_even_max", emax, 0, 4);
        chk_rng("sq_bin1", mags[1], 5857, 6875);
        chk_rng("sq_bin3", mags[3], 1952, 2292);
`ifndef FFT_HALF_SPECTRUM_EN
        chk_rng("sq_bin511", mags[511], 5857, 6875);
`endif

        run_frame(2, "dc");
        chk_rng("dc_bin0", mags[0], 9991, 10000);
        emax = 0;
        for (int k = 1; k < NB; k++) if (mags[k] > emax || mags[k] < 0) emax = (mags[k] < 0) ? 99999 : mags[k];
        chk_rng("dc_other_max", emax, 0, 9);

        run_frame(3, "impulse");
        emax = 0;
        emin = 99999;
        for (int k = 0; k < NB; k++) begin
            if (mags[k] > emax) emax = mags[k];
            if (mags[k] < emin) emin = mags[k];
        end
        chk_rng("imp_min", emin, 2046, 2050);
        chk_rng("imp_max", emax, 2046, 2050);

        pattern = 3;
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (1500) @(negedge clk);
        chk_eq("abort_busy_mid", 32'(o_fft_busy), 1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_idle("abort_reset");
        chk_eq("abort_mag", 32'(o_fft_magnitude_out), 0);
        reset = 1'b0;
        abort_err = 0;
        repeat (200) begin
            @(negedge clk);
            if (o_fft_done_pulse !== 1'b0 || o_fft_busy !== 1'b0 || o_fft_out_valid !== 1'b0)
                abort_err++;
        end
        chk_eq("abort_quiet", abort_err, 0);

        run_frame(3, "impulse2");
        emax = 0;
        emin = 99999;
        for (int k = 0; k < NB; k++) begin
            if (mags[k] > emax) emax = mags[k];
            if (mags[k] < emin) emin = mags[k];
        end
        chk_rng("imp2_min", emin, 2046, 2050);
        chk_rng("imp2_max", emax, 2046, 2050);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
